uf_somador_cdb: RTL and testbench
=================================

UF_SOMADOR_CDB -- requirements
Module: uf_somador_cdb

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, number of EXEC cycles (legal range 1..7).
REQ-002 The block SHALL have parameter Qi_CDB_data_sem_valor, default 16'b1111_1111_1111_0000, the idle CDB data value.
REQ-003 The block SHALL have parameter Qi_sem_tag, default 3'b000, meaning no station / idle CDB tag.
REQ-004 Clock  input  1  clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Ready_to_uf  input  1  operands A/B valid from the operand selector.
REQ-007 A  input  16  first operand.
REQ-008 B  input  16  second operand.
REQ-009 Op  input  2  operation: 00 ADD, 01 SUB (A-B), 10 SLT signed (result 1 or 0), 11 AND.
REQ-010 Tag_in  input  3  issuing reservation-station tag.
REQ-011 CDB_grant  input  1  CDB arbiter grant.
REQ-012 Busy_uf  output  1  unit occupied; no new operation accepted.
REQ-013 CDB_req  output  1  request for the CDB.
REQ-014 Qi_CDB  output  3  broadcast tag.
REQ-015 Qi_CDB_data  output  16  broadcast result.
REQ-016 Done  output  1  one-cycle pulse freeing the issuing station.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, WAIT_CDB, BROADCAST.
REQ-018 IDLE -> EXEC SHALL occur on an edge with Ready_to_uf=1 and Tag_in != Qi_sem_tag; A, B, Op and Tag_in are latched on that edge.
REQ-019 Ready_to_uf=1 with Tag_in=Qi_sem_tag SHALL be ignored (stay IDLE).
REQ-020 EXEC SHALL last exactly LATENCY cycles via a 3-bit down-counter, then go to WAIT_CDB.
REQ-021 The result SHALL be computed from latched operands only: 16-bit wrap-around for ADD/SUB; SLT as two's-complement compare, zero-extended.
REQ-022 CDB_req SHALL be 1 exactly while in WAIT_CDB.
REQ-023 WAIT_CDB -> BROADCAST SHALL occur on the edge sampling CDB_grant=1; with CDB_grant=0 the unit stays in WAIT_CDB indefinitely, result held.
REQ-024 BROADCAST SHALL last one cycle: Qi_CDB=latched tag, Qi_CDB_data=result, Done=1; then go to IDLE.
REQ-025 Outside BROADCAST: Qi_CDB=Qi_sem_tag, Qi_CDB_data=Qi_CDB_data_sem_valor, Done=0.
REQ-026 CDB_grant SHALL be ignored in IDLE, EXEC and BROADCAST.
REQ-027 Busy_uf SHALL be 0 only in IDLE; Ready_to_uf while busy SHALL be ignored and must not alter latched data.
REQ-028 A broadcast SHALL become visible LATENCY+1 cycles after the accept edge when the grant is immediate; a new accept is possible on the first edge after BROADCAST.
REQ-029 A result equal to Qi_CDB_data_sem_valor SHALL still be broadcast unchanged (tag qualifies the data).

Reset
REQ-030 Reset SHALL force IDLE, counter 0, Busy_uf=0, CDB_req=0, Done=0, Qi_CDB=Qi_sem_tag, Qi_CDB_data=Qi_CDB_data_sem_valor.
REQ-031 Reset mid-operation (any state) SHALL discard the operation with no broadcast and no Done pulse.

Configuration
REQ-032 With UF_OVERFLOW_FLAG_EN defined, the block SHALL add output Overflow (1 bit, reset 0), driven high only in BROADCAST when a signed ADD/SUB overflowed, else 0.
REQ-033 Without UF_OVERFLOW_FLAG_EN, no Overflow port or logic SHALL exist; all other behaviour is identical.

Verification
REQ-034 LATENCY=2, A=5, B=3, Op=00, Tag_in=3'b010, grant held 1 -> broadcast 3 cycles after the accept edge: Qi_CDB=010, data=8, Done=1 for one cycle.
REQ-035 A=3, B=5, Op=01, grant withheld 4 cycles -> CDB_req high 4 cycles, then one broadcast of data=16'hFFFE; Busy_uf high throughout.
REQ-036 Op=10, A=16'hFFFF, B=1 -> data=1; A=1, B=16'hFFFF -> data=0.
REQ-037 Second Ready_to_uf (A=9, tag 011) during EXEC -> ignored; only the first tag is broadcast; a third request after BROADCAST is accepted.
REQ-038 Reset pulse in WAIT_CDB -> all outputs at reset values, no broadcast, next request accepted normally.
REQ-039 UF_OVERFLOW_FLAG_EN defined, A=16'h7FFF, B=1, Op=00 -> data=16'h8000, Overflow=1 during BROADCAST only.

Source files
------------

// File: rtl/uf_somador_cdb.sv
// uf_somador_cdb: integer functional unit (ADD/SUB/SLT/AND) for a Tomasulo core.
// It accepts one operation from the operand selector and executes it for LATENCY
// cycles. It then requests the CDB and, once granted, broadcasts the tag and
// result for one cycle while pulsing Done.
//
// Ports:
//   Clock, Reset     - rising-edge clock, asynchronous active-high reset
//   Ready_to_uf      - operands A/B/Op/Tag_in valid
//   A, B [15:0]      - operands
//   Op [1:0]         - 00 ADD, 01 SUB (A-B), 10 SLT signed, 11 AND
//   Tag_in [2:0]     - issuing reservation-station tag
//   CDB_grant        - CDB arbiter grant
//   Busy_uf          - unit occupied (low only when idle)
//   CDB_req          - CDB request (high while waiting for grant)
//   Qi_CDB [2:0]     - broadcast tag (Qi_sem_tag when idle)
//   Qi_CDB_data      - broadcast result (Qi_CDB_data_sem_valor when idle)
//   Done             - one-cycle pulse during broadcast
//   Overflow         - only with UF_OVERFLOW_FLAG_EN: signed ADD/SUB overflow,
//                      valid during broadcast
module uf_somador_cdb #(
  parameter int unsigned LATENCY               = 2,
  parameter logic [15:0] Qi_CDB_data_sem_valor = 16'b1111_1111_1111_0000,
  parameter logic [2:0]  Qi_sem_tag            = 3'b000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Ready_to_uf,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [1:0]  Op,
  input  logic [2:0]  Tag_in,
  input  logic        CDB_grant,
  output logic        Busy_uf,
  output logic        CDB_req,
  output logic [2:0]  Qi_CDB,
  output logic [15:0] Qi_CDB_data,
  output logic        Done
`ifdef UF_OVERFLOW_FLAG_EN
  ,
  output logic        Overflow
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXEC      = 2'd1,
    WAIT_CDB  = 2'd2,
    BROADCAST = 2'd3
  } state_t;

  // Counter starts at LATENCY-1 and EXEC ends on the cycle it reads zero,
  // giving exactly LATENCY cycles in EXEC.
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  tag_q, tag_d;

  logic [15:0] result;
  logic [15:0] sum;
  logic [15:0] diff;
  logic        ovf;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tag_q   <= Qi_sem_tag;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    unique case (state_q)
      IDLE: begin
        if (Ready_to_uf && (Tag_in != Qi_sem_tag)) begin
          state_d = EXEC;
          cnt_d   = CNT_INIT;
          a_d     = A;
          b_d     = B;
          op_d    = Op;
          tag_d   = Tag_in;
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = WAIT_CDB;
        else             cnt_d   = cnt_q - 3'd1;
      end
      WAIT_CDB: begin
        if (CDB_grant) state_d = BROADCAST;
      end
      BROADCAST: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    sum  = a_q + b_q;
    diff = a_q - b_q;
    result = '0;
    ovf    = 1'b0;
    unique case (op_q)
      2'b00: begin
        result = sum;
        ovf    = (a_q[15] == b_q[15]) && (sum[15] != a_q[15]);
      end
      2'b01: begin
        result = diff;
        ovf    = (a_q[15] != b_q[15]) && (diff[15] != a_q[15]);
      end
      2'b10: result = {15'b0, ($signed(a_q) < $signed(b_q))};
      2'b11: result = a_q & b_q;
      default: result = '0;
    endcase
  end

  always_comb begin
    Busy_uf     = (state_q != IDLE);
    CDB_req     = (state_q == WAIT_CDB);
    Done        = 1'b0;
    Qi_CDB      = Qi_sem_tag;
    Qi_CDB_data = Qi_CDB_data_sem_valor;
    if (state_q == BROADCAST) begin
      Done        = 1'b1;
      Qi_CDB      = tag_q;
      Qi_CDB_data = result;
    end
  end

`ifdef UF_OVERFLOW_FLAG_EN
  assign Overflow = (state_q == BROADCAST) && ovf;
`else
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_uf_somador_cdb.sv
// Directed self-checking bench for uf_somador_cdb (default parameters).
module tb_uf_somador_cdb;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Ready_to_uf;
  logic [15:0] A, B;
  logic [1:0]  Op;
  logic [2:0]  Tag_in;
  logic        CDB_grant;
  logic        Busy_uf, CDB_req, Done;
  logic [2:0]  Qi_CDB;
  logic [15:0] Qi_CDB_data;
`ifdef UF_OVERFLOW_FLAG_EN
  logic        Overflow;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 Clock = ~Clock;

  uf_somador_cdb #(
    .LATENCY(2),
    .Qi_CDB_data_sem_valor(16'hFFF0),
    .Qi_sem_tag(3'b000)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Ready_to_uf(Ready_to_uf),
    .A(A),
    .B(B),
    .Op(Op),
    .Tag_in(Tag_in),
    .CDB_grant(CDB_grant),
    .Busy_uf(Busy_uf),
    .CDB_req(CDB_req),
    .Qi_CDB(Qi_CDB),
    .Qi_CDB_data(Qi_CDB_data),
    .Done(Done)
`ifdef UF_OVERFLOW_FLAG_EN
    ,
    .Overflow(Overflow)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, ".busy"}, 16'(Busy_uf), 16'd0);
    check({tag, ".req"},  16'(CDB_req), 16'd0);
    check({tag, ".done"}, 16'(Done), 16'd0);
    check({tag, ".tag"},  16'(Qi_CDB), 16'd0);
    check({tag, ".data"}, Qi_CDB_data, 16'hFFF0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic [2:0] tag);
    Ready_to_uf = 1'b1; A = a; B = b; Op = op; Tag_in = tag;
    tick;
    Ready_to_uf = 1'b0;
  endtask

  task automatic broadcast_check(input string tag, input logic [2:0] exp_tag,
                                 input logic [15:0] exp_data);
    check({tag, ".bc_done"}, 16'(Done), 16'd1);
    check({tag, ".bc_tag"},  16'(Qi_CDB), 16'(exp_tag));
    check({tag, ".bc_data"}, Qi_CDB_data, exp_data);
    check({tag, ".bc_req"},  16'(CDB_req), 16'd0);
  endtask

  initial begin
    Reset = 1'b1; Ready_to_uf = 1'b0; A = '0; B = '0; Op = '0; Tag_in = '0;
    CDB_grant = 1'b0;
    #12;
    idle_outputs("reset");
    Reset = 1'b0;

    // ADD 5+3, tag 2, grant held: broadcast 3 edges after accept
    CDB_grant = 1'b1;
    issue(16'd5, 16'd3, 2'b00, 3'b010);
    check("add.busy_exec1", 16'(Busy_uf), 16'd1);
    check("add.req_exec1", 16'(CDB_req), 16'd0);
    check("add.tag_exec1", 16'(Qi_CDB), 16'd0);
    tick;
    check("add.done_exec2", 16'(Done), 16'd0);
    check("add.req_exec2", 16'(CDB_req), 16'd0);
    tick;
    check("add.req_wait", 16'(CDB_req), 16'd1);
    check("add.done_wait", 16'(Done), 16'd0);
    tick;
    broadcast_check("add", 3'b010, 16'd8);
    tick;
    idle_outputs("add_after");

    // SUB 3-5 with grant withheld for 4 cycles
    CDB_grant = 1'b0;
    issue(16'd3, 16'd5, 2'b01, 3'b011);
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      check("sub.req_wait", 16'(CDB_req), 16'd1);
      check("sub.busy_wait", 16'(Busy_uf), 16'd1);
      check("sub.data_held_idle", Qi_CDB_data, 16'hFFF0);
      if (i == 3) CDB_grant = 1'b1;
      tick;
    end
    broadcast_check("sub", 3'b011, 16'hFFFE);
    check("sub.busy_bc", 16'(Busy_uf), 16'd1);
    tick;
    check("sub.done_gone", 16'(Done), 16'd0);

    // SLT signed both directions, AND, and result equal to idle value
    issue(16'hFFFF, 16'h0001, 2'b10, 3'b100);
    tick; tick; tick;
    broadcast_check("slt1", 3'b100, 16'd1);
    tick;
    issue(16'h0001, 16'hFFFF, 2'b10, 3'b101);
    tick; tick; tick;
    broadcast_check("slt0", 3'b101, 16'd0);
    tick;
    issue(16'hF0F0, 16'hFF00, 2'b11, 3'b111);
    tick; tick; tick;
    broadcast_check("and", 3'b111, 16'hF000);
    tick;
    issue(16'hFFF0, 16'h0000, 2'b00, 3'b101);
    tick; tick; tick;
    broadcast_check("semval", 3'b101, 16'hFFF0);
    tick;

    // Ready with the null tag is ignored
    issue(16'd1, 16'd1, 2'b00, 3'b000);
    check("nulltag.busy", 16'(Busy_uf), 16'd0);
    tick;
    check("nulltag.req", 16'(CDB_req), 16'd0);

    // Second request while busy is ignored; third after broadcast accepted
    issue(16'd10, 16'd20, 2'b00, 3'b001);
    Ready_to_uf = 1'b1; A = 16'd9; B = 16'd0; Op = 2'b00; Tag_in = 3'b011;
    tick; tick; tick;
    broadcast_check("busyreq", 3'b001, 16'd30);
    tick;
    check("third.idle_busy", 16'(Busy_uf), 16'd0);
    tick;
    check("third.accept_busy", 16'(Busy_uf), 16'd1);
    Ready_to_uf = 1'b0;
    tick; tick; tick;
    broadcast_check("third", 3'b011, 16'd9);
    tick;

    // Reset while waiting for the CDB discards the operation
    CDB_grant = 1'b0;
    issue(16'd1, 16'd2, 2'b00, 3'b110);
    tick; tick;
    check("rst.req_wait", 16'(CDB_req), 16'd1);
    #2 Reset = 1'b1;
    #1;
    idle_outputs("rst_async");
    CDB_grant = 1'b1;
    tick;
    idle_outputs("rst_held");
    Reset = 1'b0;
    tick;
    idle_outputs("rst_released");
    issue(16'd2, 16'd2, 2'b00, 3'b110);
    tick; tick; tick;
    broadcast_check("rst_next", 3'b110, 16'd4);
    tick;

`ifdef UF_OVERFLOW_FLAG_EN
    issue(16'h7FFF, 16'h0001, 2'b00, 3'b010);
    tick; tick;
    check("ovf.wait", 16'(Overflow), 16'd0);
    tick;
    broadcast_check("ovf", 3'b010, 16'h8000);
    check("ovf.bc", 16'(Overflow), 16'd1);
    tick;
    check("ovf.after", 16'(Overflow), 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
